// File: rtl/div_unit_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and the iteration-counter sizing helper.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } divState_t;

    // Counter must be able to hold WIDTH itself, hence the extra bit.
    function automatic int cntBits(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on magnitudes: shift {R,Q} left by one,
// subtract the divisor when it fits and record the quotient bit.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // A set top bit in remIn means the shifted value exceeds any divisor.
    assign shifted = {remIn[WIDTH-1:0], quoIn[WIDTH-1]};
    assign fits    = remIn[WIDTH] | (shifted >= {1'b0, divisor});
    assign remOut  = fits ? (shifted - {1'b0, divisor}) : shifted;
    assign quoOut  = {quoIn[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider for the HI/LO path: low = A/B (truncated toward
// zero), hi = A%B (sign of dividend); WIDTH restoring steps plus a sign fix.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divInit,
    input  logic [WIDTH-1:0] value_A,
    input  logic [WIDTH-1:0] value_B,
    output logic             busy,
    output logic             divDone,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] low
);

    localparam int CW = cntBits(WIDTH);

    divState_t        state;
    divState_t        stateNext;
    logic [CW-1:0]    count;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic             divByZero;
    logic             lastStep;

    // MIN_INT negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign absA      = value_A[WIDTH-1] ? (~value_A + 1'b1) : value_A;
    assign absB      = value_B[WIDTH-1] ? (~value_B + 1'b1) : value_B;
    assign divByZero = (value_B == '0);
    assign lastStep  = (count == CW'(WIDTH - 1));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .remIn   (rem),
        .quoIn   (quo),
        .divisor (magB),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (divInit && !divByZero) stateNext = RUN;
            RUN:     if (lastStep) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Done/zero flags are single-cycle pulses; results stay held until the
    // next completed division overwrites them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            magB    <= '0;
            rem     <= '0;
            quo     <= '0;
            hi      <= '0;
            low     <= '0;
            busy    <= 1'b0;
            divDone <= 1'b0;
            divZero <= 1'b0;
        end else begin
            divDone <= 1'b0;
            divZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (divInit) begin
                        if (divByZero) begin
                            divDone <= 1'b1;
                            divZero <= 1'b1;
                        end else begin
                            signA <= value_A[WIDTH-1];
                            signB <= value_B[WIDTH-1];
                            magB  <= absB;
                            quo   <= absA;
                            rem   <= '0;
                            count <= '0;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem   <= remNext;
                    quo   <= quoNext;
                    count <= count + 1'b1;
                end
                FIX: begin
                    low     <= (signA ^ signB) ? (~quo + 1'b1) : quo;
                    hi      <= signA ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
                    divDone <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed expected
// quotients, remainders and handshake timing.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        divInit;
    logic [31:0] value_A;
    logic [31:0] value_B;
    logic        busy;
    logic        divDone;
    logic        divZero;
    logic [31:0] hi;
    logic [31:0] low;

    int total;
    int bad;
    int edges;
    int sawDone;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .divInit (divInit),
        .value_A (value_A),
        .value_B (value_B),
        .busy    (busy),
        .divDone (divDone),
        .divZero (divZero),
        .hi      (hi),
        .low     (low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents operands at a negedge, holds divInit over the next rising edge
    // and leaves the bench just after that edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input bit hold);
        @(negedge clk);
        value_A = a;
        value_B = b;
        divInit = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) divInit = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!divDone && n < 100);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        divInit = 1'b0;
        value_A = '0;
        value_B = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_low", low, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, divDone}, 32'd0);
        checkOutput("rst_zero", {31'd0, divZero}, 32'd0);
        reset = 1'b0;

        // 100 / 7
        applyStimulus(32'd100, 32'd7, 1'b0);
        checkOutput("t1_busy_up", {31'd0, busy}, 32'd1);
        waitDone(edges);
        checkOutput("t1_latency", 32'(edges), 32'd33);
        checkOutput("t1_done", {31'd0, divDone}, 32'd1);
        checkOutput("t1_zero", {31'd0, divZero}, 32'd0);
        checkOutput("t1_busy_dn", {31'd0, busy}, 32'd0);
        checkOutput("t1_low", low, 32'd14);
        checkOutput("t1_hi", hi, 32'd2);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse", {31'd0, divDone}, 32'd0);
        checkOutput("t1_low_held", low, 32'd14);

        // -100 / 7 and 100 / -7
        applyStimulus(-32'sd100, 32'd7, 1'b0);
        waitDone(edges);
        checkOutput("t2a_low", low, 32'hFFFF_FFF2);
        checkOutput("t2a_hi", hi, 32'hFFFF_FFFE);
        applyStimulus(32'd100, -32'sd7, 1'b0);
        waitDone(edges);
        checkOutput("t2b_low", low, 32'hFFFF_FFF2);
        checkOutput("t2b_hi", hi, 32'd2);

        // Divide by zero: immediate flags, results untouched, busy stays low
        applyStimulus(32'd5, 32'd0, 1'b0);
        checkOutput("t3_done", {31'd0, divDone}, 32'd1);
        checkOutput("t3_zero", {31'd0, divZero}, 32'd1);
        checkOutput("t3_busy", {31'd0, busy}, 32'd0);
        checkOutput("t3_low", low, 32'hFFFF_FFF2);
        checkOutput("t3_hi", hi, 32'd2);
        @(posedge clk);
        #1;
        checkOutput("t3_zero_pulse", {31'd0, divZero}, 32'd0);
        checkOutput("t3_busy_after", {31'd0, busy}, 32'd0);

        // MIN_INT / -1 and MIN_INT / 1
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitDone(edges);
        checkOutput("t4a_low", low, 32'h8000_0000);
        checkOutput("t4a_hi", hi, 32'd0);
        applyStimulus(32'h8000_0000, 32'd1, 1'b0);
        waitDone(edges);
        checkOutput("t4b_low", low, 32'h8000_0000);
        checkOutput("t4b_hi", hi, 32'd0);

        // divInit held, operands changed mid-run, then back-to-back start
        applyStimulus(32'd1000, 32'd10, 1'b1);
        repeat (5) @(negedge clk);
        value_A = 32'd77;
        value_B = 32'd5;
        waitDone(edges);
        checkOutput("t5a_done", {31'd0, divDone}, 32'd1);
        checkOutput("t5a_low", low, 32'd100);
        checkOutput("t5a_hi", hi, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t5_b2b_busy", {31'd0, busy}, 32'd1);
        divInit = 1'b0;
        waitDone(edges);
        checkOutput("t5b_latency", 32'(edges), 32'd33);
        checkOutput("t5b_low", low, 32'd15);
        checkOutput("t5b_hi", hi, 32'd2);

        // Reset at iteration 10 aborts silently
        applyStimulus(32'd12345, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_rst_low", low, 32'd0);
        checkOutput("t6_rst_hi", hi, 32'd0);
        reset = 1'b0;
        sawDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (divDone) sawDone++;
        end
        checkOutput("t6_no_done", 32'(sawDone), 32'd0);
        applyStimulus(32'd7, 32'd7, 1'b0);
        waitDone(edges);
        checkOutput("t6_latency", 32'(edges), 32'd33);
        checkOutput("t6_low", low, 32'd1);
        checkOutput("t6_hi", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
